alu_serial: RTL and testbench
=============================

ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal range 2..64).
REQ-002 SHALL have clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have start_i, input, 1 bit: operation request, sampled on the rising edge of clk_i.
REQ-005 SHALL have src1_i, input, WIDTH bits: operand A.
REQ-006 SHALL have src2_i, input, WIDTH bits: operand B.
REQ-007 SHALL have ALU_control_i, input, 4 bits: operation code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR).
REQ-008 SHALL have result_o, output, WIDTH bits: registered result.
REQ-009 SHALL have zero_o, output, 1 bit: result_o equals 0.
REQ-010 SHALL have cout_o, output, 1 bit: final carry out.
REQ-011 SHALL have overflow_o, output, 1 bit: signed overflow.
REQ-012 SHALL have busy_o, output, 1 bit: operation in progress.
REQ-013 SHALL have done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL use states IDLE, RUN, FINISH, plus a bit counter of ceil(log2(WIDTH)) bits and a 1-bit carry register.
REQ-015 SHALL, in IDLE with start_i=1, latch src1_i, src2_i and ALU_control_i, clear the counter, load carry with 1 for SUB/SLT and 0 otherwise, and enter RUN.
REQ-016 SHALL ignore start_i in RUN and FINISH; latched operands SHALL NOT change mid-operation.
REQ-017 SHALL, in RUN, process exactly one bit per cycle, LSB first, with counter i as the bit index.
REQ-018 SHALL form the per-bit operands a = A_invert ? ~A[i] : A[i] and b = B_invert ? ~B[i] : B[i].
REQ-019 SHALL set A_invert = 1 only for NOR, and B_invert = 1 for NOR, SUB and SLT.
REQ-020 SHALL produce the per-bit result as a&b for AND/NOR, a|b for OR, and a^b^carry for ADD/SUB/SLT.
REQ-021 SHALL update carry to the full-adder carry out of (a, b, carry) after each bit.
REQ-022 SHALL record the carry into bit WIDTH-1 for overflow computation.
REQ-023 SHALL move from RUN to FINISH on the edge that processes bit WIDTH-1.
REQ-024 SHALL, on the FINISH edge, register result_o, zero_o, cout_o and overflow_o, assert done_o, and return to IDLE.
REQ-025 SHALL give fixed latency: with start sampled at edge 0, done_o is high for exactly the cycle after edge WIDTH+1, deasserting at edge WIDTH+2 unless a new operation completes then.
REQ-026 SHALL, for ADD/SUB, set cout_o to the final carry and overflow_o to (carry into MSB) XOR (carry out).
REQ-027 SHALL, for SLT, set result_o = {zeros, sumMSB XOR overflow} with cout_o = 0 and overflow_o = 0.
REQ-028 SHALL, for AND/OR/NOR, set cout_o = 0 and overflow_o = 0.
REQ-029 SHALL, for any unlisted ALU_control_i code, set result_o = 0, cout_o = 0, overflow_o = 0 and zero_o = 1, with the same latency.
REQ-030 SHALL drive busy_o = 1 exactly in RUN and FINISH.
REQ-031 SHALL accept start_i during the done_o cycle, giving back-to-back operations.
REQ-032 SHALL hold result_o and all flags stable from done_o until the next FINISH edge.

Reset
REQ-033 SHALL, on rst_i=1, immediately force state IDLE, the counter, the carry register and all latched operands to 0, independent of clk_i.
REQ-034 SHALL, on rst_i=1, immediately force result_o = 0, zero_o = 0, cout_o = 0, overflow_o = 0, busy_o = 0 and done_o = 0.
REQ-035 SHALL, on reset during RUN or FINISH, abort the operation with no done_o pulse.
REQ-036 SHALL honour start_i on the first rising edge after rst_i deasserts.

Verification (WIDTH=32)
REQ-037 SHALL cover ADD 0x7FFFFFFF+0x00000001 -> result_o 0x80000000, overflow_o 1, cout_o 0, zero_o 0, done_o in the cycle after edge 33.
REQ-038 SHALL cover SUB 0x00000005-0x00000005 -> result_o 0, zero_o 1, cout_o 1, overflow_o 0.
REQ-039 SHALL cover SLT 0xFFFFFFFF vs 0x00000001 -> result_o 1, and SLT 0x7FFFFFFF vs 0x80000000 -> result_o 0 (overflow path).
REQ-040 SHALL cover AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000; OR of the same operands -> 0xFFF0FFF0; NOR 0,0 -> 0xFFFFFFFF; code 1111 -> result_o 0, zero_o 1.
REQ-041 SHALL cover a start_i pulse mid-RUN -> ignored, original result unchanged; and rst_i asserted at bit 10 -> busy_o 0 at once, no done_o, all outputs 0.
REQ-042 SHALL cover start_i held high across the done_o cycle -> second operation accepted, second done_o exactly 34 cycles after the first.

Source files
------------

// File: rtl/alu_serial.sv
// Bit-serial ALU: processes one operand bit per clock, LSB first, then registers
// the result and flags and pulses done_o for one cycle.
module alu_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ALU_control_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             carry_msb;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       op;
  logic [WIDTH-1:0] sum;

  logic             a_inv;
  logic             b_inv;
  logic             a_bit;
  logic             b_bit;
  logic             bit_res;
  logic             carry_nxt;

  logic             ovf;
  logic [WIDTH-1:0] fin_result;
  logic             fin_cout;
  logic             fin_ovf;

  // One slice of the classic MIPS-style ALU, evaluated for the current bit index.
  always_comb begin
    a_inv     = (op == OP_NOR);
    b_inv     = (op == OP_NOR) || (op == OP_SUB) || (op == OP_SLT);
    a_bit     = a_inv ? ~a_reg[cnt] : a_reg[cnt];
    b_bit     = b_inv ? ~b_reg[cnt] : b_reg[cnt];
    carry_nxt = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    case (op)
      OP_AND, OP_NOR:         bit_res = a_bit & b_bit;
      OP_OR:                  bit_res = a_bit | b_bit;
      OP_ADD, OP_SUB, OP_SLT: bit_res = a_bit ^ b_bit ^ carry;
      default:                bit_res = 1'b0;
    endcase
  end

  always_comb begin
    ovf        = carry_msb ^ carry;
    fin_result = '0;
    fin_cout   = 1'b0;
    fin_ovf    = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_NOR: fin_result = sum;
      OP_ADD, OP_SUB: begin
        fin_result = sum;
        fin_cout   = carry;
        fin_ovf    = ovf;
      end
      OP_SLT:  fin_result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      default: fin_result = '0;
    endcase
  end

  // The result shifts in from the top so bit 0 lands at the LSB after WIDTH steps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      carry      <= 1'b0;
      carry_msb  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      op         <= '0;
      sum        <= '0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            a_reg  <= src1_i;
            b_reg  <= src2_i;
            op     <= ALU_control_i;
            cnt    <= '0;
            carry  <= (ALU_control_i == OP_SUB) || (ALU_control_i == OP_SLT);
            sum    <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum   <= {bit_res, sum[WIDTH-1:1]};
          carry <= carry_nxt;
          if (cnt == LAST) begin
            carry_msb <= carry;
            state     <= FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          result_o   <= fin_result;
          zero_o     <= (fin_result == '0);
          cout_o     <= fin_cout;
          overflow_o <= fin_ovf;
          done_o     <= 1'b1;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial (WIDTH=32): directed corner cases, random
// operations against an arithmetic reference model, and control-flow scenarios.
module tb_alu_serial;

  localparam int WIDTH = 32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ctrl;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        ovf;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  alu_serial #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .src1_i       (src1),
    .src2_i       (src2),
    .ALU_control_i(ctrl),
    .result_o     (result),
    .zero_o       (zero),
    .cout_o       (cout),
    .overflow_o   (ovf),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from arithmetic definitions; returns {zero, cout, overflow, result}.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic [32:0] t;
    logic [31:0] r;
    logic        c;
    logic        v;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[31:0];
        c = t[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0110: begin
        t = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = t[31:0];
        c = t[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {(r == 32'd0), c, v, r};
  endfunction

  // Launches one operation (releasing reset on the same negedge) and waits for done.
  task automatic exec_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         output logic [34:0] obs, output int lat, output logic bsy);
    @(negedge clk);
    rst   = 1'b0;
    src1  = a;
    src2  = b;
    ctrl  = op;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bsy = busy;
    lat = -1;
    for (int cyc = 1; cyc <= WIDTH + 8; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = cyc;
        break;
      end
    end
    obs = {zero, cout, ovf, result};
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    src1  = '0;
    src2  = '0;
    ctrl  = '0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({result, zero, cout, ovf, busy, done} !== 37'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h required 0", {result, zero, cout, ovf, busy, done});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_held: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [31:0] da [8] = '{32'h7FFFFFFF, 32'h5, 32'hFFFFFFFF, 32'h7FFFFFFF,
                            32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0, 32'h12345678};
    logic [31:0] db [8] = '{32'h1, 32'h5, 32'h1, 32'h80000000,
                            32'hFF00FF00, 32'hFF00FF00, 32'h0, 32'h9ABCDEF0};
    logic [3:0]  dop [8] = '{4'b0010, 4'b0110, 4'b0111, 4'b0111,
                             4'b0000, 4'b0001, 4'b1100, 4'b1111};
    logic [34:0] dexp [8] = '{{3'b001, 32'h80000000}, {3'b110, 32'h0},
                              {3'b000, 32'h1}, {3'b100, 32'h0},
                              {3'b000, 32'hF000F000}, {3'b000, 32'hFFF0FFF0},
                              {3'b000, 32'hFFFFFFFF}, {3'b100, 32'h0}};
    logic [34:0] obs;
    int          lat;
    logic        bsy;
    for (int i = 0; i < 8; i++) begin
      exec_op(da[i], db[i], dop[i], obs, lat, bsy);
      checks++;
      if (obs !== dexp[i]) begin
        errors++;
        $display("[TB] FAIL directed_%0d: got {z,c,v,r}=%h required %h", i, obs, dexp[i]);
      end
      checks++;
      if (lat !== WIDTH + 1 || bsy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL directed_latency_%0d: got lat=%0d busy=%b required %0d 1",
                 i, lat, bsy, WIDTH + 1);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] held;
    logic [34:0] obs;
    int          lat;
    logic        bsy;
    exec_op(32'hDEADBEEF, 32'h01234567, 4'b0010, obs, lat, bsy);
    held = result;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== held) begin
        errors++;
        $display("[TB] FAIL hold_%0d: got done=%b busy=%b result=%h required 0 0 %h",
                 k, done, busy, result, held);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    logic [31:0] corner [4] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [34:0] obs;
    logic [34:0] exp;
    int          lat;
    logic        bsy;
    for (int n = 0; n < 30; n++) begin
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      op = ($urandom_range(0, 6) == 6) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 5)];
      exp = model(a, b, op);
      exec_op(a, b, op, obs, lat, bsy);
      checks++;
      if (obs !== exp || lat !== WIDTH + 1) begin
        errors++;
        $display("[TB] FAIL random_%0d: op=%b a=%h b=%h got %h lat=%0d required %h lat=%0d",
                 n, op, a, b, obs, lat, exp, WIDTH + 1);
      end
    end
  endtask

  task automatic test_mid_run_start();
    int d = -1;
    @(negedge clk);
    src1  = 32'd3;
    src2  = 32'd4;
    ctrl  = 4'b0010;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 1; e <= WIDTH + 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) begin
        src1  = 32'hFFFFFFFF;
        src2  = 32'hAAAAAAAA;
        ctrl  = 4'b0000;
        start = 1'b1;
      end
      if (e == 6) start = 1'b0;
      if (done) begin
        d = e;
        break;
      end
    end
    checks++;
    if (d !== WIDTH + 1 || {zero, cout, ovf, result} !== model(32'd3, 32'd4, 4'b0010)) begin
      errors++;
      $display("[TB] FAIL mid_run_start: got lat=%0d result=%h required %0d %h",
               d, result, WIDTH + 1, 32'd7);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_run_no_relaunch: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [34:0] obs;
    int          lat;
    logic        bsy;
    int          early = 0;
    @(negedge clk);
    src1  = 32'hF0F0F0F0;
    src2  = 32'h0F0F0F0F;
    ctrl  = 4'b0001;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({result, zero, cout, ovf, busy, done} !== 37'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run: got %h required 0", {result, zero, cout, ovf, busy, done});
    end
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("[TB] FAIL reset_abort: got %0d active cycles required 0", early);
    end
    exec_op(32'h0000FFFF, 32'h00000001, 4'b0010, obs, lat, bsy);
    checks++;
    if (obs !== model(32'h0000FFFF, 32'h1, 4'b0010) || lat !== WIDTH + 1 || bsy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_after_reset: got %h lat=%0d busy=%b required %h %0d 1",
               obs, lat, bsy, model(32'h0000FFFF, 32'h1, 4'b0010), WIDTH + 1);
    end
  endtask

  task automatic test_back_to_back();
    int          d1 = -1;
    int          d2 = -1;
    logic [34:0] r1 = '0;
    logic [34:0] r2 = '0;
    @(negedge clk);
    src1  = 32'h7FFFFFFF;
    src2  = 32'h00000001;
    ctrl  = 4'b0010;
    start = 1'b1;
    @(posedge clk);
    #1;
    src1 = 32'd5;
    src2 = 32'd5;
    ctrl = 4'b0110;
    for (int e = 1; e <= 3 * WIDTH; e++) begin
      @(posedge clk);
      #1;
      if (e == WIDTH + 2) start = 1'b0;
      if (done && d1 < 0) begin
        d1 = e;
        r1 = {zero, cout, ovf, result};
      end else if (done && d2 < 0 && e != d1) begin
        d2 = e;
        r2 = {zero, cout, ovf, result};
        break;
      end
    end
    checks++;
    if (d1 !== WIDTH + 1 || d2 - d1 !== WIDTH + 2) begin
      errors++;
      $display("[TB] FAIL back_to_back_timing: got d1=%0d d2=%0d required %0d %0d",
               d1, d2, WIDTH + 1, 2 * WIDTH + 3);
    end
    checks++;
    if (r1 !== model(32'h7FFFFFFF, 32'h1, 4'b0010) || r2 !== model(32'd5, 32'd5, 4'b0110)) begin
      errors++;
      $display("[TB] FAIL back_to_back_results: got %h %h required %h %h", r1, r2,
               model(32'h7FFFFFFF, 32'h1, 4'b0010), model(32'd5, 32'd5, 4'b0110));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_mid_run_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
